aer_out_encoder: RTL and testbench
==================================

Name: aer_out_encoder

Overview:
- Transmit side of the spike AER link: takes the 4-lane post-synaptic spike vector produced per 128-bit neuron word and queues it.
- Serializes it into 10-bit neuron address events on an asynchronous 4-phase REQ/ACK output bus.
- Sits between the neuron core spike outputs and the chip-level AER output pads; the off-chip receiver is the ACK source.

Parameters:
- FIFO_DEPTH, 8, number of queued spike groups (power of 2, ≥2).
- ADDR_W, 10, width of the output neuron address.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- NEUR_EVENT_IN  in  4  per-lane spike flags for one neuron group, valid for one cycle.
- NEUR_GROUP_ADDR  in  8  group address = post-neuron address[9:2], valid with NEUR_EVENT_IN.
- SPI_GATE_ACTIVITY_sync  in  1  configuration active: new pushes are ignored.
- OVF_CLR  in  1  clears the sticky overflow flag.
- AEROUT_ACK  in  1  asynchronous acknowledge from the receiver.
- AEROUT_REQ  out  1  event request, registered.
- AEROUT_ADDR  out  10  event address {group, lane}, registered.
- FIFO_OVF  out  1  sticky: a group was dropped because the FIFO was full.
- AER_BUSY  out  1  FIFO not empty OR FSM not IDLE.

Behaviour:
- Reset state: AEROUT_REQ=0, AEROUT_ADDR=0, FIFO_OVF=0, AER_BUSY=0, FIFO empty, FSM=IDLE, ACK synchronizer=0.
- ACK synchronizer: AEROUT_ACK passes through a 2-FF synchronizer to give ack_s. The FSM uses only ack_s.
- Push condition: NEUR_EVENT_IN != 0 AND SPI_GATE_ACTIVITY_sync == 0.
  - Writes the entry {NEUR_GROUP_ADDR, NEUR_EVENT_IN} (12 bits).
  - An all-zero vector is never pushed.
- Full FIFO: a push is accepted if the FIFO is not full, or if a pop happens in the same cycle. Otherwise the entry is dropped and FIFO_OVF is set.
  - FIFO_OVF stays set until OVF_CLR=1.
  - If OVF_CLR and a new overflow occur in the same cycle, the overflow wins (flag stays 1).
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full/empty are decided by comparing the MSB of the pointers.
- FSM states: IDLE, LOAD, REQ_HI, ACK_LO.
  - IDLE: if the FIFO is not empty, go to LOAD.
  - LOAD: pop the head into group_r and mask_r. Set AEROUT_ADDR = {group, lowest set lane index}, AEROUT_REQ <= 1, go to REQ_HI.
  - REQ_HI: hold REQ and ADDR. On ack_s=1: REQ <= 0, clear the served bit in mask_r, go to ACK_LO.
  - ACK_LO: wait for ack_s=0. Then:
    - if mask_r != 0: ADDR <= next lowest lane, REQ <= 1, go to REQ_HI;
    - else if the FIFO is not empty: go to LOAD;
    - else go to IDLE.
- Lane order: within a group, lanes are served lowest index first (lane 0 first). Address = NEUR_GROUP_ADDR*4 + lane.
- Latency: for a push sampled at edge t with the FIFO empty and the FSM in IDLE, AEROUT_REQ rises after edge t+2.
- REQ deassert: REQ falls on the 3rd edge after AEROUT_ACK rises (2 synchronizer edges + 1 FSM edge).
- Address stability: AEROUT_ADDR changes only when REQ=0 and ack_s=0. It is stable throughout REQ high and the ACK-low wait.
- Simultaneous events: push and pop in the same cycle on a non-full FIFO → both take effect and the occupancy is unchanged.
- Reset mid-handshake: REQ drops to 0 immediately (asynchronously). All queued groups and mask_r are lost; FIFO_OVF is cleared.
- SPI_GATE_ACTIVITY_sync does not stall draining of already-queued events.

Decomposition:
- Shared package (aer_pkg):
  - FSM state encoding;
  - AER_ADDR_W=10;
  - GROUP_W=8;
  - LANES=4;
  - a function that returns the lowest set bit index of a 4-bit mask.
- One sub-module, aer_sync_fifo: a synchronous FIFO with FIFO_DEPTH entries of 12 bits. It provides push, pop, full, empty and read-first head data. The FSM and the ACK synchronizer stay in the top module.

Test Plan:
- Single spike: push group 0x05, mask 4'b0100 with an ACK responder of 3-cycle delay. Expect REQ high 2 edges after the push, ADDR=0x016, then the full 4-phase handshake, then AER_BUSY=0 and IDLE.
- Multi-lane: push group 0x3F, mask 4'b1011. Expect three handshakes in order with ADDR 0x0FC, 0x0FD, 0x0FF, and ADDR stable while REQ=1.
- Back-to-back groups: push groups 0x01 mask 4'b0001 and 0x02 mask 4'b1000 on consecutive cycles. Expect ADDR 0x004 then 0x00B, with no event lost.
- Overflow: hold ACK low, push FIFO_DEPTH+2 groups. Expect FIFO_OVF=1 and exactly FIFO_DEPTH+1 groups delivered (one held in mask_r, plus a full FIFO) after ACK resumes. Pulse OVF_CLR → FIFO_OVF=0.
- Gating: SPI_GATE_ACTIVITY_sync=1 while pushing mask 4'b1111. Expect no push and AER_BUSY stays 0. An already queued group still drains.
- Reset mid-operation: assert RST while REQ=1. Expect REQ=0 at once. After release, no further REQ occurs and FIFO_OVF=0.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared definitions for the AER transmit path: handshake FSM encoding,
// address geometry and the lane-priority helper.
package aer_pkg;
  localparam int AER_ADDR_W = 10;
  localparam int GROUP_W    = 8;
  localparam int LANES      = 4;
  localparam int LANE_W     = 2;
  localparam int ENTRY_W    = GROUP_W + LANES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ_HI,
    ST_ACK_LO
  } aer_state_e;

  // Lane 0 has the highest priority, so scan downwards and keep the last hit.
  function automatic logic [LANE_W-1:0] lowest_lane(input logic [LANES-1:0] mask);
    lowest_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) lowest_lane = LANE_W'(i);
    end
  endfunction
endpackage

// File: rtl/aer_out_encoder_if.sv
// Off-chip 4-phase AER output bus: the encoder drives REQ/ADDR, the receiver returns ACK.
interface aer_out_encoder_if #(parameter int ADDR_W = aer_pkg::AER_ADDR_W);
  logic              AEROUT_REQ;
  logic [ADDR_W-1:0] AEROUT_ADDR;
  logic              AEROUT_ACK;

  modport master (output AEROUT_REQ, output AEROUT_ADDR, input AEROUT_ACK);
  modport slave  (input AEROUT_REQ, input AEROUT_ADDR, output AEROUT_ACK);
endinterface

// File: rtl/aer_sync_fifo.sv
// Synchronous FIFO of spike groups with read-first head data; pointers carry
// one extra wrap bit so full and empty are told apart by the MSB.
module aer_sync_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign wr_en   = push_i && (!full_o || rd_en);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/aer_out_encoder.sv
// AER transmit encoder: queues per-group spike vectors and serialises them,
// lowest lane first, as {group, lane} events on a 4-phase REQ/ACK bus.
module aer_out_encoder
  import aer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = AER_ADDR_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [LANES-1:0]   NEUR_EVENT_IN,
  input  logic [GROUP_W-1:0] NEUR_GROUP_ADDR,
  input  logic               SPI_GATE_ACTIVITY_sync,
  input  logic               OVF_CLR,
  aer_out_encoder_if.master  aer,
  output logic               FIFO_OVF,
  output logic               AER_BUSY
);
  aer_state_e         state_q;
  logic [GROUP_W-1:0] group_q;
  logic [LANES-1:0]   mask_q;
  logic               req_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               ack_meta_q, ack_s_q, ovf_q;

  logic               push_req, fifo_pop, fifo_full, fifo_empty, ovf_set;
  logic [ENTRY_W-1:0] fifo_head;
  logic [GROUP_W-1:0] head_group_d;
  logic [LANES-1:0]   head_mask_d;
  logic [LANE_W-1:0]  load_lane_d, next_lane_d;

  assign push_req     = (NEUR_EVENT_IN != '0) && !SPI_GATE_ACTIVITY_sync;
  assign fifo_pop     = (state_q == ST_LOAD);
  assign ovf_set      = push_req && fifo_full && !fifo_pop;
  assign head_group_d = fifo_head[ENTRY_W-1:LANES];
  assign head_mask_d  = fifo_head[LANES-1:0];
  assign load_lane_d  = lowest_lane(head_mask_d);
  assign next_lane_d  = lowest_lane(mask_q);

  aer_sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (push_req),
    .pop_i   (fifo_pop),
    .din_i   ({NEUR_GROUP_ADDR, NEUR_EVENT_IN}),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ACK comes straight from the pads; only the synchronised copy reaches the FSM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= aer.AEROUT_ACK;
      ack_s_q    <= ack_meta_q;
    end
  end

  // A fresh overflow outranks a clear arriving in the same cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (OVF_CLR) ovf_q <= 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      group_q <= '0;
      mask_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          group_q <= head_group_d;
          mask_q  <= head_mask_d;
          addr_q  <= {head_group_d, load_lane_d};
          req_q   <= 1'b1;
          state_q <= ST_REQ_HI;
        end
        ST_REQ_HI: begin
          if (ack_s_q) begin
            req_q                        <= 1'b0;
            mask_q[addr_q[LANE_W-1:0]]   <= 1'b0;
            state_q                      <= ST_ACK_LO;
          end
        end
        ST_ACK_LO: begin
          if (!ack_s_q) begin
            if (mask_q != '0) begin
              addr_q  <= {group_q, next_lane_d};
              req_q   <= 1'b1;
              state_q <= ST_REQ_HI;
            end else if (!fifo_empty) begin
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign aer.AEROUT_REQ  = req_q;
  assign aer.AEROUT_ADDR = addr_q;
  assign FIFO_OVF        = ovf_q;
  assign AER_BUSY        = !fifo_empty || (state_q != ST_IDLE);
endmodule

// File: tb/tb_aer_out_encoder.sv
// Bench for aer_out_encoder: ACK responder, event monitor and a queue-based
// model of which address events the receiver must see, in order.
module tb_aer_out_encoder;
  localparam int DEPTH = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] ev = '0;
  logic [7:0] grp = '0;
  logic       gate = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       FIFO_OVF, AER_BUSY;

  aer_out_encoder_if #(.ADDR_W(10)) aer ();

  aer_out_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(10)) dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .NEUR_EVENT_IN          (ev),
    .NEUR_GROUP_ADDR        (grp),
    .SPI_GATE_ACTIVITY_sync (gate),
    .OVF_CLR                (ovf_clr),
    .aer                    (aer),
    .FIFO_OVF               (FIFO_OVF),
    .AER_BUSY               (AER_BUSY)
  );

  always #5 CLK = ~CLK;

  int         checks = 0, failures = 0;
  int         stab_err = 0;
  logic [9:0] got[$];
  logic [9:0] exp_q[$];
  logic       req_prev = 1'b0;
  logic [9:0] addr_prev = '0;
  bit         resp_en = 1'b1;
  int         resp_dly = 3;

  // Receiver: raise ACK resp_dly cycles after REQ, drop it resp_dly cycles after REQ falls.
  initial begin
    aer.AEROUT_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (resp_en && aer.AEROUT_REQ === 1'b1) begin
        repeat (resp_dly) @(negedge CLK);
        aer.AEROUT_ACK = 1'b1;
        while (aer.AEROUT_REQ === 1'b1) @(negedge CLK);
        repeat (resp_dly) @(negedge CLK);
        aer.AEROUT_ACK = 1'b0;
      end
    end
  end

  // Record each REQ rise and flag any ADDR change that is not part of a new request.
  always @(negedge CLK) begin
    if (!RST) begin
      if (aer.AEROUT_REQ && !req_prev) got.push_back(aer.AEROUT_ADDR);
      if (aer.AEROUT_ADDR !== addr_prev && !(aer.AEROUT_REQ && !req_prev))
        stab_err <= stab_err + 1;
    end
    req_prev  <= aer.AEROUT_REQ;
    addr_prev <= aer.AEROUT_ADDR;
  end

  // Reference: every accepted group yields group*4+lane for each set lane, ascending.
  task automatic model_group(input logic [7:0] g, input logic [3:0] m);
    for (int l = 0; l < 4; l++)
      if (m[l]) exp_q.push_back(10'(g) * 10'd4 + 10'(l));
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge CLK); #1;
      if (!AER_BUSY && !aer.AEROUT_REQ && !aer.AEROUT_ACK) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (aer.AEROUT_REQ !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", aer.AEROUT_REQ); end
    checks++; if (aer.AEROUT_ADDR !== 10'h000) begin failures++; $display("FAIL rst_addr got=%h exp=000", aer.AEROUT_ADDR); end
    checks++; if (FIFO_OVF !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", FIFO_OVF); end
    checks++; if (AER_BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", AER_BUSY); end
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    checks++; if (AER_BUSY !== 1'b0 || aer.AEROUT_REQ !== 1'b0) begin failures++; $display("FAIL rst_release busy=%b req=%b exp=0/0", AER_BUSY, aer.AEROUT_REQ); end
  endtask

  task automatic test_single_spike;
    int base = got.size(), s0 = stab_err, n = 1;
    bit ok;
    exp_q.delete(); resp_en = 1; resp_dly = 3;
    model_group(8'h05, 4'b0100);
    @(negedge CLK); ev = 4'b0100; grp = 8'h05;
    @(posedge CLK); #1;
    checks++; if (aer.AEROUT_REQ !== 1'b0 || AER_BUSY !== 1'b1) begin failures++; $display("FAIL single_t0 req=%b busy=%b exp=0/1", aer.AEROUT_REQ, AER_BUSY); end
    @(negedge CLK); ev = '0;
    @(posedge CLK); #1;
    checks++; if (aer.AEROUT_REQ !== 1'b0) begin failures++; $display("FAIL single_t1 req=%b exp=0", aer.AEROUT_REQ); end
    @(posedge CLK); #1;
    checks++; if (aer.AEROUT_REQ !== 1'b1 || aer.AEROUT_ADDR !== 10'h016) begin failures++; $display("FAIL single_t2 req=%b addr=%h exp=1/016", aer.AEROUT_REQ, aer.AEROUT_ADDR); end
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      if (aer.AEROUT_ACK) break;
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      if (!aer.AEROUT_REQ) break;
      @(posedge CLK); n++;
    end
    checks++; if (n != 3) begin failures++; $display("FAIL single_req_fall edges=%0d exp=3", n); end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_idle timeout got=busy exp=idle"); end
    checks++; if (got.size() - base != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", got.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (base + i >= got.size() || got[base+i] !== exp_q[i]) begin failures++; $display("FAIL single_addr%0d got=%h exp=%h", i, (base + i < got.size()) ? got[base+i] : 10'h3ff, exp_q[i]); end
    end
    checks++; if (stab_err != s0) begin failures++; $display("FAIL single_stable got=%0d exp=%0d", stab_err, s0); end
  endtask

  task automatic test_multi_lane;
    int base = got.size(), s0 = stab_err;
    bit ok;
    exp_q.delete(); resp_dly = 2;
    model_group(8'h3F, 4'b1011);
    @(negedge CLK); ev = 4'b1011; grp = 8'h3F;
    @(negedge CLK); ev = '0;
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL multi_idle timeout got=busy exp=idle"); end
    checks++; if (got.size() - base != exp_q.size()) begin failures++; $display("FAIL multi_count got=%0d exp=%0d", got.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (base + i >= got.size() || got[base+i] !== exp_q[i]) begin failures++; $display("FAIL multi_addr%0d got=%h exp=%h", i, (base + i < got.size()) ? got[base+i] : 10'h3ff, exp_q[i]); end
    end
    checks++; if (stab_err != s0) begin failures++; $display("FAIL multi_stable got=%0d exp=%0d", stab_err, s0); end
  endtask

  task automatic test_back_to_back;
    int base = got.size();
    bit ok;
    exp_q.delete(); resp_dly = 1;
    model_group(8'h01, 4'b0001);
    model_group(8'h02, 4'b1000);
    @(negedge CLK); ev = 4'b0001; grp = 8'h01;
    @(negedge CLK); ev = 4'b1000; grp = 8'h02;
    @(negedge CLK); ev = '0;
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_idle timeout got=busy exp=idle"); end
    checks++; if (got.size() - base != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (base + i >= got.size() || got[base+i] !== exp_q[i]) begin failures++; $display("FAIL b2b_addr%0d got=%h exp=%h", i, (base + i < got.size()) ? got[base+i] : 10'h3ff, exp_q[i]); end
    end
  endtask

  task automatic test_overflow;
    int base = got.size(), accepted = 0;
    bit ok;
    logic [7:0] g;
    logic [3:0] m;
    exp_q.delete(); resp_en = 0; resp_dly = 1;
    for (int i = 1; i <= DEPTH + 3; i++) begin
      g = 8'($urandom_range(0, 255));
      m = 4'($urandom_range(1, 15));
      // Capacity with ACK stalled: one group held by the serializer plus a full FIFO.
      if (accepted < DEPTH + 1) begin model_group(g, m); accepted++; end
      @(negedge CLK);
      if (i == DEPTH + 3) begin
        checks++; if (FIFO_OVF !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", FIFO_OVF); end
        ovf_clr = 1'b1;
      end
      ev = m; grp = g;
    end
    @(negedge CLK); ev = '0; ovf_clr = 1'b0;
    checks++; if (FIFO_OVF !== 1'b1) begin failures++; $display("FAIL ovf_vs_clr got=%b exp=1", FIFO_OVF); end
    resp_en = 1;
    wait_idle(3000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_idle timeout got=busy exp=idle"); end
    checks++; if (got.size() - base != exp_q.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", got.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (base + i >= got.size() || got[base+i] !== exp_q[i]) begin failures++; $display("FAIL ovf_addr%0d got=%h exp=%h", i, (base + i < got.size()) ? got[base+i] : 10'h3ff, exp_q[i]); end
    end
    checks++; if (FIFO_OVF !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", FIFO_OVF); end
    @(negedge CLK); ovf_clr = 1'b1;
    @(negedge CLK); ovf_clr = 1'b0;
    checks++; if (FIFO_OVF !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", FIFO_OVF); end
  endtask

  task automatic test_gating;
    int base = got.size();
    bit ok;
    logic [3:0] m;
    exp_q.delete(); resp_dly = 2;
    gate = 1'b1;
    @(negedge CLK); ev = 4'b1111; grp = 8'h22;
    @(negedge CLK); ev = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      checks++; if (AER_BUSY !== 1'b0) begin failures++; $display("FAIL gate_busy%0d got=%b exp=0", c, AER_BUSY); end
    end
    m = 4'($urandom_range(1, 15));
    model_group(8'h11, m);
    @(negedge CLK); gate = 1'b0; ev = m; grp = 8'h11;
    @(negedge CLK); gate = 1'b1; ev = 4'b1111; grp = 8'h33;
    @(negedge CLK); ev = '0;
    wait_idle(300, ok);
    gate = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL gate_idle timeout got=busy exp=idle"); end
    checks++; if (got.size() - base != exp_q.size()) begin failures++; $display("FAIL gate_count got=%0d exp=%0d", got.size() - base, exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (base + i >= got.size() || got[base+i] !== exp_q[i]) begin failures++; $display("FAIL gate_addr%0d got=%h exp=%h", i, (base + i < got.size()) ? got[base+i] : 10'h3ff, exp_q[i]); end
    end
  endtask

  task automatic test_random;
    bit ok;
    logic [7:0] g;
    logic [3:0] m;
    logic gt;
    for (int r = 0; r < 6; r++) begin
      int base = got.size(), s0 = stab_err;
      int n = $urandom_range(1, DEPTH);
      exp_q.delete();
      resp_dly = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) begin
        g  = 8'($urandom_range(0, 255));
        m  = 4'($urandom_range(0, 15));
        gt = ($urandom_range(0, 3) == 0);
        if (m != 4'd0 && !gt) model_group(g, m);
        @(negedge CLK); ev = m; grp = g; gate = gt;
        repeat ($urandom_range(0, 2)) begin
          @(negedge CLK); ev = '0; gate = 1'b0;
        end
      end
      @(negedge CLK); ev = '0; gate = 1'b0;
      wait_idle(1500, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_idle timeout got=busy exp=idle", r); end
      checks++; if (got.size() - base != exp_q.size()) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", r, got.size() - base, exp_q.size()); end
      foreach (exp_q[i]) begin
        checks++;
        if (base + i >= got.size() || got[base+i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_addr%0d got=%h exp=%h", r, i, (base + i < got.size()) ? got[base+i] : 10'h3ff, exp_q[i]); end
      end
      checks++; if (stab_err != s0 || FIFO_OVF !== 1'b0) begin failures++; $display("FAIL rnd%0d_stable_ovf stab=%0d ovf=%b exp=%0d/0", r, stab_err, FIFO_OVF, s0); end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    resp_en = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge CLK); ev = 4'b1111; grp = 8'(8'h40 + i);
    end
    @(negedge CLK); ev = '0;
    checks++; if (aer.AEROUT_REQ !== 1'b1 || FIFO_OVF !== 1'b1) begin failures++; $display("FAIL rmid_pre req=%b ovf=%b exp=1/1", aer.AEROUT_REQ, FIFO_OVF); end
    #2 RST = 1'b1;
    #1;
    checks++; if (aer.AEROUT_REQ !== 1'b0) begin failures++; $display("FAIL rmid_req got=%b exp=0", aer.AEROUT_REQ); end
    checks++; if (FIFO_OVF !== 1'b0 || AER_BUSY !== 1'b0) begin failures++; $display("FAIL rmid_ovf_busy ovf=%b busy=%b exp=0/0", FIFO_OVF, AER_BUSY); end
    checks++; if (aer.AEROUT_ADDR !== 10'h000) begin failures++; $display("FAIL rmid_addr got=%h exp=000", aer.AEROUT_ADDR); end
    @(negedge CLK); RST = 1'b0;
    base = got.size();
    resp_en = 1;
    repeat (40) @(posedge CLK);
    #1;
    checks++; if (got.size() != base) begin failures++; $display("FAIL rmid_no_req got=%0d exp=0", got.size() - base); end
    checks++; if (aer.AEROUT_REQ !== 1'b0 || FIFO_OVF !== 1'b0 || AER_BUSY !== 1'b0) begin failures++; $display("FAIL rmid_after req=%b ovf=%b busy=%b exp=0/0/0", aer.AEROUT_REQ, FIFO_OVF, AER_BUSY); end
  endtask

  initial begin
    test_reset();
    test_single_spike();
    test_multi_lane();
    test_back_to_back();
    test_overflow();
    test_gating();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
